calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SETUP_CYC, default 1: cycles operands are held stable before strobe, legal range 1..15.
REQ-003 Parameter RESP_LAT, default 1: wait cycles between strobe and result sampling, legal range 1..15.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 btnu  in  1  synchronous active-high reset.
REQ-006 start  in  1  level; sampled only in IDLE; begins a program run.
REQ-007 stop_on_fail  in  1  when 1, run ends at first mismatch.
REQ-008 led  in  16  calculator accumulator output, checked against expected value.
REQ-009 drv_btnu  out  1  reset pulse to calculator.
REQ-010 drv_btnl, drv_btnc, drv_btnr  out  1 each  op-select to calculator.
REQ-011 drv_btnd  out  1  one-cycle accumulate strobe to calculator.
REQ-012 drv_sw  out  16  operand to calculator.
REQ-013 busy  out  1  high from start acceptance until DONE entered.
REQ-014 done  out  1  high in DONE until next accepted start or reset.
REQ-015 pass  out  1  valid with done; 1 iff err_cnt==0 and all 9 steps executed.
REQ-016 err_cnt  out  4  mismatch count, saturates at 15.
REQ-017 step  out  4  current program index 0..8; holds last executed index in DONE.
REQ-018 bad_led  out  16  led value captured at the most recent mismatch.

Function
REQ-019 Program table SHALL be fixed, 9 entries of {btnl,btnc,btnr}, operand, expected:
  0: 010 354A -> 354A | 1: 011 1234 -> 2316 | 2: 001 1001 -> 3317
  3: 000 F0F0 -> 3010 | 4: 111 1FA2 -> 2FB2 | 5: 010 6AA2 -> 9A54
  6: 101 0004 -> A540 | 7: 110 0001 -> D2A0 | 8: 100 46FF -> 0001
REQ-020 FSM states SHALL be IDLE, CRST, SETUP, STROBE, WAIT, CHECK, DONE.
REQ-021 IDLE or DONE with start=1 -> CRST; clears err_cnt, bad_led, step, pass, done; asserts busy.
REQ-022 CRST SHALL last exactly 1 cycle with drv_btnu=1, then go to SETUP.
REQ-023 SETUP SHALL drive op bits and drv_sw from table[step] for SETUP_CYC cycles, then go to STROBE.
REQ-024 STROBE SHALL last 1 cycle with drv_btnd=1, with op and operand still driven, then go to WAIT.
REQ-025 WAIT SHALL last RESP_LAT cycles with drv_btnd=0, then go to CHECK.
REQ-026 CHECK SHALL last 1 cycle and compare led to expected.
  - On mismatch: err_cnt increments (saturating) and bad_led is set to led.
REQ-027 CHECK exit SHALL be:
  - to DONE if step==8, or on mismatch with stop_on_fail=1;
  - otherwise step increments and the FSM goes to SETUP.
REQ-028 Op bits and drv_sw SHALL hold the current step's values from SETUP through CHECK, and SHALL be 0 in IDLE, CRST and DONE.
REQ-029 drv_btnd and drv_btnu SHALL never be high in the same cycle, and each SHALL be high at most 1 consecutive cycle.
REQ-030 Run length SHALL be 1 + 9*(SETUP_CYC+2+RESP_LAT) cycles from start acceptance to DONE entry (37 at defaults).
REQ-031 pass SHALL be set on DONE entry only when step==8 and err_cnt==0; an early stop gives pass=0.
REQ-032 start SHALL be ignored while busy; stop_on_fail SHALL be sampled in CHECK only.
REQ-033 Comparison SHALL be a full 16-bit equality; led is treated as unsigned with no masking.

Reset
REQ-034 btnu=1 at any edge SHALL force IDLE and clear all outputs, registers and counters to 0, including drv_btnu.
REQ-035 Reset mid-run SHALL abort without completing the current strobe; next start reruns from step 0.
REQ-036 start high in the same cycle as btnu SHALL be ignored.

Verification
REQ-037 Connect to a correct calc model, defaults, start pulse -> drv_btnu at cycle 1, done at cycle 37, pass=1, err_cnt=0, step=8.
REQ-038 Model with step-3 result forced to 3011, stop_on_fail=0 -> all 9 steps run, err_cnt=1 or more, bad_led holds last bad led value, pass=0.
REQ-039 Same fault, stop_on_fail=1 -> done after CHECK of step 3, step=3, err_cnt=1, bad_led=3011, pass=0.
REQ-040 Assert btnu during WAIT of step 5 -> next cycle IDLE with all outputs 0; rerun gives pass=1.
REQ-041 SETUP_CYC=3, RESP_LAT=2 -> done at cycle 1+9*7=64; drv_btnd pulses exactly 9 times, each 1 cycle wide.
REQ-042 Toggle start while busy, then start again in DONE -> mid-run start has no effect; DONE start clears done and reruns.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: control, status and calculator-drive signals of the sequencer
interface calc_sequencer_if;
  logic start;
  logic stop_on_fail;
  logic [15:0] led;
  logic drv_btnu;
  logic drv_btnl;
  logic drv_btnc;
  logic drv_btnr;
  logic drv_btnd;
  logic [15:0] drv_sw;
  logic busy;
  logic done;
  logic pass;
  logic [3:0] err_cnt;
  logic [3:0] step;
  logic [15:0] bad_led;
  modport master (
    input start, stop_on_fail, led,
    output drv_btnu, drv_btnl, drv_btnc, drv_btnr, drv_btnd, drv_sw,
    output busy, done, pass, err_cnt, step, bad_led
  );
  modport slave (
    output start, stop_on_fail, led,
    input drv_btnu, drv_btnl, drv_btnc, drv_btnr, drv_btnd, drv_sw,
    input busy, done, pass, err_cnt, step, bad_led
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: drives a fixed 9-step program into a calculator and checks each result
module calc_sequencer #(
  parameter int SETUP_CYC = 1,
  parameter int RESP_LAT = 1
) (
  input logic clk,
  input logic btnu,
  calc_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, CRST, SETUP, STROBE, WAIT, CHECK, DONE} state_t;
  localparam logic [2:0] OPS [9] = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b111,
                                     3'b010, 3'b101, 3'b110, 3'b100};
  localparam logic [15:0] OPR [9] = '{16'h354A, 16'h1234, 16'h1001, 16'hF0F0, 16'h1FA2,
                                      16'h6AA2, 16'h0004, 16'h0001, 16'h46FF};
  localparam logic [15:0] EXP [9] = '{16'h354A, 16'h2316, 16'h3317, 16'h3010, 16'h2FB2,
                                      16'h9A54, 16'hA540, 16'hD2A0, 16'h0001};
  state_t state;
  logic [3:0] cnt;
  logic [3:0] nxt;
  logic miss;
  logic last;
  assign nxt = bus.step + 4'd1;
  assign miss = bus.led != EXP[bus.step];
  assign last = bus.step == 4'd8;
  always_ff @(posedge clk)
    if (btnu) begin
      state <= IDLE;
      cnt <= '0;
      bus.drv_btnu <= 1'b0;
      {bus.drv_btnl, bus.drv_btnc, bus.drv_btnr} <= 3'b000;
      bus.drv_btnd <= 1'b0;
      bus.drv_sw <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.err_cnt <= '0;
      bus.step <= '0;
      bus.bad_led <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (bus.start) begin
            state <= CRST;
            bus.drv_btnu <= 1'b1;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.err_cnt <= '0;
            bus.step <= '0;
            bus.bad_led <= '0;
          end
        CRST: begin
          bus.drv_btnu <= 1'b0;
          {bus.drv_btnl, bus.drv_btnc, bus.drv_btnr} <= OPS[0];
          bus.drv_sw <= OPR[0];
          cnt <= 4'(SETUP_CYC - 1);
          state <= SETUP;
        end
        SETUP:
          if (cnt == 4'd0) begin
            bus.drv_btnd <= 1'b1;
            state <= STROBE;
          end else cnt <= cnt - 4'd1;
        STROBE: begin
          bus.drv_btnd <= 1'b0;
          cnt <= 4'(RESP_LAT - 1);
          state <= WAIT;
        end
        WAIT:
          if (cnt == 4'd0) state <= CHECK;
          else cnt <= cnt - 4'd1;
        CHECK: begin
          if (miss) begin
            bus.err_cnt <= bus.err_cnt + {3'b000, bus.err_cnt != 4'hF};
            bus.bad_led <= bus.led;
          end
          if (last || (miss && bus.stop_on_fail)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= last && !miss && bus.err_cnt == 4'd0;
            {bus.drv_btnl, bus.drv_btnc, bus.drv_btnr} <= 3'b000;
            bus.drv_sw <= '0;
          end else begin
            bus.step <= nxt;
            {bus.drv_btnl, bus.drv_btnc, bus.drv_btnr} <= OPS[nxt];
            bus.drv_sw <= OPR[nxt];
            cnt <= 4'(SETUP_CYC - 1);
            state <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: two sequencer configurations against a calculator model and a timing model
module tb_calc_sequencer;
  typedef struct packed {
    logic busy, done, pass;
    logic [3:0] err, step;
    logic [15:0] bad;
    logic ub, bl, bc, br, bd;
    logic [15:0] sw;
  } outs_t;
  localparam logic [2:0] T_OP [9] = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b111,
                                      3'b010, 3'b101, 3'b110, 3'b100};
  localparam logic [15:0] T_OPR [9] = '{16'h354A, 16'h1234, 16'h1001, 16'hF0F0, 16'h1FA2,
                                        16'h6AA2, 16'h0004, 16'h0001, 16'h46FF};
  localparam logic [15:0] T_EXP [9] = '{16'h354A, 16'h2316, 16'h3317, 16'h3010, 16'h2FB2,
                                        16'h9A54, 16'hA540, 16'hD2A0, 16'h0001};
  logic clk = 1'b0;
  logic btnu, start, sof, fault;
  bit armed;
  int checks, failures;
  int da, db;
  outs_t obs [2];
  int pc_v [2];
  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b011: return a - b;
      3'b100: return {15'b0, $signed(a) < $signed(b)};
      3'b101: return a << b[3:0];
      3'b110: return $signed(a) >>> b[3:0];
      default: return a ^ b;
    endcase
  endfunction

  // what the outputs must be t cycles after start acceptance
  function automatic outs_t exp_out(input int s, input int r, input int t, input bit act,
                                    input bit sf, input bit flt);
    outs_t o;
    logic [15:0] acc, la [9];
    bit mm [9];
    int last, p, tdone, n, ec, i;
    o = '0;
    if (!act) return o;
    acc = '0;
    for (int j = 0; j < 9; j++) begin
      acc = alu(T_OP[j], acc, T_OPR[j]);
      if (flt && j == 3) acc = 16'h3011;
      la[j] = acc;
      mm[j] = acc != T_EXP[j];
    end
    last = 8;
    for (int j = 8; j >= 0; j--) if (sf && mm[j]) last = j;
    p = s + 2 + r;
    tdone = 2 + (last + 1) * p;
    n = t >= tdone ? last + 1 : (t < 2 ? 0 : (t - 2) / p);
    ec = 0;
    for (int j = 0; j < n; j++) if (mm[j]) begin ec++; o.bad = la[j]; end
    o.err = 4'(ec > 15 ? 15 : ec);
    if (t >= tdone) begin
      o.done = 1'b1;
      o.step = 4'(last);
      o.pass = last == 8 && ec == 0;
    end else begin
      o.busy = 1'b1;
      if (t == 1) o.ub = 1'b1;
      else begin
        i = (t - 2) / p;
        o.step = 4'(i);
        {o.bl, o.bc, o.br} = T_OP[i];
        o.sw = T_OPR[i];
        o.bd = (t - 2) % p == s;
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d at %0t: got %h want %h", nm, g, $time, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = g == 0 ? 1 : 3;
    localparam int R = g == 0 ? 1 : 2;
    calc_sequencer_if bus ();
    calc_sequencer #(.SETUP_CYC(S), .RESP_LAT(R)) dut (.clk(clk), .btnu(btnu), .bus(bus.master));
    logic [15:0] acc;
    int ns, t, pc;
    bit act, sof_c, flt_c;
    outs_t ex;
    assign bus.start = start;
    assign bus.stop_on_fail = sof;
    assign bus.led = acc;
    assign obs[g] = {bus.busy, bus.done, bus.pass, bus.err_cnt, bus.step, bus.bad_led,
                     bus.drv_btnu, bus.drv_btnl, bus.drv_btnc, bus.drv_btnr, bus.drv_btnd, bus.drv_sw};
    assign pc_v[g] = pc;
    always_comb ex = exp_out(S, R, t, act, sof_c, flt_c);
    always @(posedge clk)
      if (btnu || bus.drv_btnu) begin
        acc <= '0;
        ns <= 0;
      end else if (bus.drv_btnd) begin
        acc <= (fault && ns == 3) ? 16'h3011 : alu({bus.drv_btnl, bus.drv_btnc, bus.drv_btnr}, acc, bus.drv_sw);
        ns <= ns + 1;
      end
    always @(posedge clk) begin
      if (bus.drv_btnd) pc <= pc + 1;
      if (btnu) begin
        act <= 1'b0;
        t <= 0;
      end else if (start && !ex.busy) begin
        act <= 1'b1;
        t <= 1;
        sof_c <= sof;
        flt_c <= fault;
        pc <= 0;
      end else if (act) t <= t + 1;
    end
    always @(negedge clk)
      if (armed) begin
        chk("busy", g, obs[g].busy, ex.busy);
        chk("done", g, obs[g].done, ex.done);
        chk("pass", g, obs[g].pass, ex.pass);
        chk("err_cnt", g, obs[g].err, ex.err);
        chk("step", g, obs[g].step, ex.step);
        chk("bad_led", g, obs[g].bad, ex.bad);
        chk("drv_btnu", g, obs[g].ub, ex.ub);
        chk("op", g, {obs[g].bl, obs[g].bc, obs[g].br}, {ex.bl, ex.bc, ex.br});
        chk("drv_btnd", g, obs[g].bd, ex.bd);
        chk("drv_sw", g, obs[g].sw, ex.sw);
      end
  end

  task automatic do_run(input bit toggle, output int a, output int b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = -1;
    b = -1;
    for (int c = 0; c < 200; c++) begin
      if (toggle) start = c >= 10 && c < 13;
      if (obs[0].done && a < 0) a = c;
      if (obs[1].done && b < 0) b = c;
      if (a >= 0 && b >= 0) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    btnu = 1'b1;
    start = 1'b0;
    sof = 1'b0;
    fault = 1'b0;
    repeat (3) @(negedge clk);
    btnu = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("reset_a", 0, obs[0], '0);
    chk("reset_b", 1, obs[1], '0);
    do_run(1'b1, da, db);
    chk("clean_done_cyc", 0, da, 37);
    chk("clean_done_cyc", 1, db, 64);
    chk("clean_pass", 0, obs[0].pass, 1);
    chk("clean_err", 0, obs[0].err, 0);
    chk("clean_step", 0, obs[0].step, 8);
    chk("strobes", 0, pc_v[0], 9);
    chk("strobes", 1, pc_v[1], 9);
    fault = 1'b1;
    do_run(1'b0, da, db);
    chk("fault_done_cyc", 0, da, 37);
    chk("fault_err", 0, obs[0].err, 5);
    chk("fault_bad", 0, obs[0].bad, 16'hD2A8);
    chk("fault_pass", 0, obs[0].pass, 0);
    sof = 1'b1;
    do_run(1'b0, da, db);
    chk("stop_done_cyc", 0, da, 17);
    chk("stop_done_cyc", 1, db, 29);
    chk("stop_step", 0, obs[0].step, 3);
    chk("stop_err", 0, obs[0].err, 1);
    chk("stop_bad", 0, obs[0].bad, 16'h3011);
    chk("stop_pass", 0, obs[0].pass, 0);
    chk("stop_strobes", 0, pc_v[0], 4);
    fault = 1'b0;
    sof = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    chk("wait5_step", 0, obs[0].step, 5);
    chk("wait5_busy", 0, obs[0].busy, 1);
    btnu = 1'b1;
    start = 1'b1;
    @(negedge clk);
    btnu = 1'b0;
    start = 1'b0;
    chk("abort_a", 0, obs[0], '0);
    chk("abort_b", 1, obs[1], '0);
    @(negedge clk);
    chk("abort_idle", 0, obs[0].busy, 0);
    do_run(1'b0, da, db);
    chk("rerun_done_cyc", 0, da, 37);
    chk("rerun_pass", 0, obs[0].pass, 1);
    chk("rerun_pass", 1, obs[1].pass, 1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
